// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

    // Serial frame phases
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity modes
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Level of an idle line (also the stop-bit level)
    localparam logic LINE_IDLE = 1'b1;

    // Parity bit to transmit, given the XOR of all data bits
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Shared baud generator: emits a one-cycle tick every DIV clocks.
module uart_baud_gen #(
    parameter int DIV = 5
) (
    input  logic clock,
    input  logic reset_n,
    output logic o_baud_tick
);

    logic [15:0] r_cnt;

    // Divide the system clock down to the bit rate
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            o_baud_tick <= 1'b0;
        end else if (r_cnt == 16'(DIV - 1)) begin
            r_cnt       <= '0;
            o_baud_tick <= 1'b1;
        end else begin
            r_cnt       <= r_cnt + 16'd1;
            o_baud_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// A one-entry holding register lets the host queue the next byte mid-frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_baud_tick,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_txd,
    output logic                 o_busy
);

    uart_state_e          r_state;
    uart_state_e          w_state_next;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 r_par;
    logic                 r_stop_cnt;
    logic                 r_txd;

    logic                 w_accept;
    logic                 w_load;
    logic                 w_last_bit;
    logic                 w_last_stop;
    logic                 w_hold_full_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [2:0]           w_bit_cnt_next;
    logic                 w_par_next;
    logic                 w_stop_cnt_next;
    logic                 w_txd_next;

    assign o_tx_ready  = !r_hold_full && reset_n;
    assign o_txd       = r_txd;
    assign o_busy      = (r_state != ST_IDLE) || r_hold_full;
    assign w_accept    = i_tx_valid && o_tx_ready;
    assign w_last_bit  = (r_bit_cnt == 3'(DATA_BITS - 1));
    assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));

    // State register plus the holding/shift datapath
    always_ff @(posedge clock) begin
        // NOTE: datapath registers are reset too, so an abandoned frame leaves no stale byte or count behind.
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_par       <= 1'b0;
            r_stop_cnt  <= 1'b0;
            r_txd       <= LINE_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
            r_state     <= w_state_next;
            r_hold_full <= w_hold_full_next;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_par       <= w_par_next;
            r_stop_cnt  <= w_stop_cnt_next;
            r_txd       <= w_txd_next;
            if (w_accept) begin
                r_hold <= i_tx_data;
            end
        end
    end

    // Next-state logic: every transition waits for a baud tick
    always_comb begin
        // NOTE: default first so no path leaves the next state unassigned (no latch).
        w_state_next = r_state;
        if (i_baud_tick) begin
            unique case (r_state)
                ST_IDLE:   if (r_hold_full) w_state_next = ST_START;
                ST_START:  w_state_next = ST_DATA;
                ST_DATA:   if (w_last_bit) w_state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP:   if (w_last_stop) w_state_next = r_hold_full ? ST_START : ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output/datapath logic: next line level, shifter, counters and handshake
    always_comb begin
        w_load          = 1'b0;
        w_txd_next      = r_txd;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_par_next      = r_par;
        w_stop_cnt_next = r_stop_cnt;
        if (i_baud_tick) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        w_load       = 1'b1;
                        w_shift_next = r_hold;
                        w_par_next   = 1'b0;
                        w_txd_next   = 1'b0;
                    end
                end
                ST_START: begin
                    w_txd_next     = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_par_next     = r_par ^ r_shift[0];
                    w_bit_cnt_next = '0;
                end
                ST_DATA: begin
                    if (w_last_bit) begin
                        w_txd_next      = (PARITY != PARITY_NONE) ? parity_bit(r_par, PARITY) : LINE_IDLE;
                        w_stop_cnt_next = 1'b0;
                    end else begin
                        w_txd_next     = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                        w_par_next     = r_par ^ r_shift[0];
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
                ST_PARITY: begin
                    w_txd_next      = LINE_IDLE;
                    w_stop_cnt_next = 1'b0;
                end
                ST_STOP: begin
                    if (w_last_stop) begin
                        if (r_hold_full) begin
                            w_load       = 1'b1;
                            w_shift_next = r_hold;
                            w_par_next   = 1'b0;
                            w_txd_next   = 1'b0;
                        end else begin
                            w_txd_next = LINE_IDLE;
                        end
                    end else begin
                        w_stop_cnt_next = 1'b1;
                    end
                end
                default: w_txd_next = LINE_IDLE;
            endcase
        end
        // Accept needs an empty holder and load needs a full one, so they never coincide
        w_hold_full_next = w_accept ? 1'b1 : (w_load ? 1'b0 : r_hold_full);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four configurations, table-driven frames,
// hand-written latency/reset sequences and randomized traffic against a bit-level frame model.
module tb_uart_tx;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       w_tick;
    logic [3:0] v_valid;
    logic [7:0] v_data [4];
    wire  [3:0] v_ready;
    wire  [3:0] v_txd;
    wire  [3:0] v_busy;

    int cfg_db  [4] = '{8, 8, 8, 5};
    int cfg_par [4] = '{0, 1, 2, 2};
    int cfg_stb [4] = '{1, 1, 2, 1};

    int n_checks = 0;
    int n_errors = 0;

    bit cap [4][256];
    int cap_n [4];
    bit cap_en [4];
    logic tick_n = 1'b0;

    bit exp_bits [256];
    int exp_n;

    typedef struct {
        int         idx;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        int         exp_par;
    } vec_t;
    vec_t vecs [9];

    always #5 clock = ~clock;

    uart_baud_gen #(.DIV(5)) u_baud (.clock(clock), .reset_n(reset_n), .o_baud_tick(w_tick));

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .i_baud_tick(w_tick), .i_tx_data(v_data[0]),
        .i_tx_valid(v_valid[0]), .o_tx_ready(v_ready[0]), .o_txd(v_txd[0]), .o_busy(v_busy[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .i_baud_tick(w_tick), .i_tx_data(v_data[1]),
        .i_tx_valid(v_valid[1]), .o_tx_ready(v_ready[1]), .o_txd(v_txd[1]), .o_busy(v_busy[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .i_baud_tick(w_tick), .i_tx_data(v_data[2]),
        .i_tx_valid(v_valid[2]), .o_tx_ready(v_ready[2]), .o_txd(v_txd[2]), .o_busy(v_busy[2]));
    uart_tx #(.DATA_BITS(5), .PARITY(2), .STOP_BITS(1)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .i_baud_tick(w_tick), .i_tx_data(v_data[3][4:0]),
        .i_tx_valid(v_valid[3]), .o_tx_ready(v_ready[3]), .o_txd(v_txd[3]), .o_busy(v_busy[3]));

    // Remember whether the coming rising edge carries a tick
    always @(negedge clock) tick_n = w_tick;

    // Record the line level of every enabled DUT once per bit period
    always @(posedge clock) begin
        if (tick_n) begin
            #1;
            for (int i = 0; i < 4; i++) begin
                if (cap_en[i] && cap_n[i] < 256) begin
                    cap[i][cap_n[i]] = v_txd[i];
                    cap_n[i]++;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic push_exp(input bit b);
        exp_bits[exp_n] = b;
        exp_n++;
    endtask

    // Frame model: start, LSB-first data, parity from the count of ones, stop bits
    task automatic exp_frame(input int idx, input logic [7:0] b);
        int ones;
        ones = 0;
        push_exp(1'b0);
        for (int i = 0; i < cfg_db[idx]; i++) begin
            push_exp(b[i]);
            ones += int'(b[i]);
        end
        if (cfg_par[idx] == 1) push_exp(bit'(ones % 2));
        else if (cfg_par[idx] == 2) push_exp(bit'(1 - ones % 2));
        for (int i = 0; i < cfg_stb[idx]; i++) push_exp(1'b1);
    endtask

    task automatic wait_tick();
        int t;
        t = 0;
        @(negedge clock);
        while (!w_tick && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!w_tick) check("tick_timeout", {63'd0, w_tick}, 64'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input int idx);
        int t;
        t = 0;
        while (!v_ready[idx] && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (!v_ready[idx]) check($sformatf("ready_timeout%0d", idx), {63'd0, v_ready[idx]}, 64'd1);
    endtask

    task automatic wait_idle(input int idx);
        int t;
        t = 0;
        while (v_busy[idx] && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (v_busy[idx]) check($sformatf("busy_timeout%0d", idx), {63'd0, v_busy[idx]}, 64'd0);
    endtask

    task automatic begin_cap(input int idx);
        cap_n[idx]  = 0;
        cap_en[idx] = 1'b1;
        exp_n       = 0;
    endtask

    // Compare captured line (after leading idle) with the model plus two idle bits
    task automatic compare_line(input int idx, input string name, output int k);
        logic [63:0] got;
        logic [63:0] want;
        cap_en[idx] = 1'b0;
        got  = '1;
        want = '1;
        k    = 0;
        while (k < cap_n[idx] && cap[idx][k] == 1'b1) k++;
        for (int i = 0; i < exp_n + 2 && i < 64; i++) begin
            want[i] = (i < exp_n) ? exp_bits[i] : 1'b1;
            if (k + i < cap_n[idx]) got[i] = cap[idx][k + i];
        end
        check(name, got, want);
    endtask

    // Send one or two bytes with valid held high, then let the line go idle
    task automatic send_seq(input int idx, input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input string name, output int k);
        begin_cap(idx);
        @(negedge clock);
        v_valid[idx] = 1'b1;
        v_data[idx]  = b0;
        wait_ready(idx);
        @(posedge clock);
        @(negedge clock);
        check({name, "_rdy_low0"}, {63'd0, v_ready[idx]}, 64'd0);
        exp_frame(idx, b0);
        if (n == 2) begin
            v_data[idx] = b1;
            wait_ready(idx);
            @(posedge clock);
            @(negedge clock);
            check({name, "_rdy_low1"}, {63'd0, v_ready[idx]}, 64'd0);
            exp_frame(idx, b1);
        end
        v_valid[idx] = 1'b0;
        v_data[idx]  = 8'($urandom);
        wait_idle(idx);
        wait_tick();
        wait_tick();
        compare_line(idx, {name, "_line"}, k);
        check({name, "_idle"}, {62'd0, v_ready[idx], v_busy[idx]}, 64'b10);
    endtask

    initial begin
        int k;
        int t;
        logic [7:0] b0;
        logic [7:0] b1;

        vecs[0] = '{idx: 0, n: 1, b0: 8'hA5, b1: 8'h00, exp_par: -1};
        vecs[1] = '{idx: 1, n: 1, b0: 8'hA5, b1: 8'h00, exp_par: 0};
        vecs[2] = '{idx: 2, n: 1, b0: 8'hA5, b1: 8'h00, exp_par: 1};
        vecs[3] = '{idx: 1, n: 1, b0: 8'h01, b1: 8'h00, exp_par: 1};
        vecs[4] = '{idx: 2, n: 1, b0: 8'h01, b1: 8'h00, exp_par: 0};
        vecs[5] = '{idx: 0, n: 2, b0: 8'h00, b1: 8'hFF, exp_par: -1};
        vecs[6] = '{idx: 2, n: 2, b0: 8'h3C, b1: 8'hC3, exp_par: 1};
        vecs[7] = '{idx: 3, n: 1, b0: 8'hE3, b1: 8'h00, exp_par: 1};
        vecs[8] = '{idx: 1, n: 2, b0: 8'h55, b1: 8'hAA, exp_par: 0};

        for (int i = 0; i < 4; i++) begin
            v_data[i] = 8'h00;
            cap_en[i] = 1'b0;
            cap_n[i]  = 0;
        end
        v_valid = 4'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_ready", {60'd0, v_ready}, 64'h0);
        check("reset_txd", {60'd0, v_txd}, 64'hF);
        check("reset_busy", {60'd0, v_busy}, 64'h0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_reset_ready", {60'd0, v_ready}, 64'hF);

        // Idle ticks leave the line high
        repeat (3) wait_tick();
        check("idle_ticks_txd", {60'd0, v_txd}, 64'hF);

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            send_seq(vecs[i].idx, vecs[i].n, vecs[i].b0, vecs[i].b1, $sformatf("vec%0d", i), k);
            if (vecs[i].exp_par >= 0) begin
                check($sformatf("vec%0d_parity", i),
                      {63'd0, cap[vecs[i].idx][k + 1 + cfg_db[vecs[i].idx]]}, 64'(vecs[i].exp_par));
            end
        end

        // Exact 0xA5 waveform with no parity: start, 1,0,1,0,0,1,0,1, stop
        send_seq(0, 1, 8'hA5, 8'h00, "a5_literal", k);
        check("a5_literal_bits",
              {54'd0, cap[0][k], cap[0][k+1], cap[0][k+2], cap[0][k+3], cap[0][k+4],
               cap[0][k+5], cap[0][k+6], cap[0][k+7], cap[0][k+8], cap[0][k+9]},
              64'b0_10100101_1);

        // Reset during data bit 3 of 0x55 abandons the frame
        @(negedge clock);
        v_valid[0] = 1'b1;
        v_data[0]  = 8'h55;
        wait_ready(0);
        @(posedge clock);
        @(negedge clock);
        v_valid[0] = 1'b0;
        wait_tick();
        check("rst_start_bit", {63'd0, v_txd[0]}, 64'd0);
        repeat (4) wait_tick();
        check("rst_bit3", {63'd0, v_txd[0]}, 64'd0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_ready_low", {63'd0, v_ready[0]}, 64'd0);
        @(posedge clock);
        #1;
        check("rst_txd_busy", {62'd0, v_txd[0], v_busy[0]}, 64'b10);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst_ready_back", {63'd0, v_ready[0]}, 64'd1);
        begin_cap(0);
        repeat (12) wait_tick();
        cap_en[0] = 1'b0;
        t = 0;
        for (int i = 0; i < cap_n[0]; i++) t += int'(cap[0][i]);
        check("rst_no_resume", 64'(t), 64'(cap_n[0]));
        send_seq(0, 1, 8'h55, 8'h00, "rst_new_frame", k);

        // Acceptance on a tick edge: line holds for that tick, falls on the next
        @(negedge clock);
        t = 0;
        while (!w_tick && t < 20) begin
            @(negedge clock);
            t++;
        end
        begin_cap(0);
        exp_frame(0, 8'h81);
        v_valid[0] = 1'b1;
        v_data[0]  = 8'h81;
        @(posedge clock);
        #1;
        check("lat_accept", {62'd0, v_ready[0], v_txd[0]}, 64'b01);
        @(negedge clock);
        v_valid[0] = 1'b0;
        v_data[0]  = 8'h00;
        wait_tick();
        check("lat_fall", {63'd0, v_txd[0]}, 64'd0);
        wait_idle(0);
        wait_tick();
        wait_tick();
        compare_line(0, "lat_line", k);
        check("lat_first_two", {62'd0, cap[0][0], cap[0][1]}, 64'b10);

        // Randomized traffic against the frame model
        for (int i = 0; i < 24; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            send_seq(int'($urandom_range(0, 3)), int'($urandom_range(1, 2)), b0, b1,
                     $sformatf("rnd%0d", i), k);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
